result_uart_serializer: RTL and testbench

Downstream stage of the 10x10 binary matrix multiplier. Captures the packed product vector (100 entries x 4 bits) on a load pulse. Streams the matrix as ASCII hex text, byte by byte, to the UART transmitter through a valid/ready byte handshake. Output format is one text line per matrix row: entries separated by spaces, each line terminated by CR LF.

---
 rtl/result_uart_serializer.sv | 124 ++++++++++++
 tb/tb_result_uart_serializer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/result_uart_serializer.sv
// Streams a captured ROWS x COLS result matrix as ASCII hex text over a byte
// valid/ready handshake: one line per row, entries space-separated, CR LF ended.
module result_uart_serializer #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int EW   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [ROWS*COLS*EW-1:0]   result_in,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready
);

  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

  typedef enum logic [2:0] {IDLE, DIGIT, SPACE, CR, LF, DONE} state_t;

  state_t              state_reg, state_next;
  logic [N*EW-1:0]     shadow_reg, shadow_next;
  logic [RW-1:0]       r_reg, r_next;
  logic [CW-1:0]       c_reg, c_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic [3:0]          entry [N];
  logic [KW-1:0]       idx_next;
  logic [3:0]          digit_val;
  logic [7:0]          digit_ascii;

  // Entries are decoded from the next-cycle shadow so the byte register can
  // be loaded in the same edge that moves the counters.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      assign entry[gi] = 4'(shadow_next[gi*EW +: EW]);
    end
  endgenerate

  assign idx_next    = KW'(r_next) * KW'(COLS) + KW'(c_next);
  assign digit_val   = entry[idx_next];
  assign digit_ascii = (digit_val < 4'd10) ? (8'h30 + {4'h0, digit_val})
                                           : (8'h37 + {4'h0, digit_val});

  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    r_next      = r_reg;
    c_next      = c_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          shadow_next = result_in;
          r_next      = '0;
          c_next      = '0;
          state_next  = DIGIT;
        end
      end
      DIGIT: if (tx_ready) state_next = (c_reg == C_LAST) ? CR : SPACE;
      SPACE: begin
        if (tx_ready) begin
          c_next     = c_reg + CW'(1);
          state_next = DIGIT;
        end
      end
      CR:    if (tx_ready) state_next = LF;
      LF: begin
        if (tx_ready) begin
          if (r_reg != R_LAST) begin
            r_next     = r_reg + RW'(1);
            c_next     = '0;
            state_next = DIGIT;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte register holds its value outside sending states.
  always_comb begin
    tx_data_next = tx_data_reg;
    case (state_next)
      DIGIT:   tx_data_next = digit_ascii;
      SPACE:   tx_data_next = 8'h20;
      CR:      tx_data_next = 8'h0D;
      LF:      tx_data_next = 8'h0A;
      default: tx_data_next = tx_data_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shadow_reg  <= '0;
      r_reg       <= '0;
      c_reg       <= '0;
      tx_data_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      shadow_reg  <= shadow_next;
      r_reg       <= r_next;
      c_reg       <= c_next;
      tx_data_reg <= tx_data_next;
    end
  end

  // Decoded straight from the state register so reset drops them at once.
  assign tx_valid = (state_reg == DIGIT) || (state_reg == SPACE) ||
                    (state_reg == CR)    || (state_reg == LF);
  assign busy     = tx_valid;
  assign done     = (state_reg == DONE);
  assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_result_uart_serializer.sv
// Directed bench for result_uart_serializer: frames checked byte by byte
// against a text-format model, plus backpressure, ignored load and reset.
module tb_result_uart_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [399:0] result_in = '0;
  logic         busy, done, tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready = 1'b1;

  int tests = 0;
  int fails = 0;
  logic [7:0] got [210];

  result_uart_serializer dut (
    .clk(clk), .rst(rst), .load(load), .result_in(result_in),
    .busy(busy), .done(done), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [399:0] m, input int i);
    int row, pos;
    logic [3:0] v;
    row = i / 21;
    pos = i % 21;
    if (pos == 20) return 8'h0A;
    if (pos == 19) return 8'h0D;
    if (pos % 2 == 1) return 8'h20;
    v = m[(row*10 + pos/2)*4 +: 4];
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h41 + {4'h0, v} - 8'd10);
  endfunction

  // Waits one edge (leaving a possible DONE cycle), pulses load for one cycle.
  task automatic do_load(input logic [399:0] m);
    @(posedge clk); #1;
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    result_in = m;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("first_valid", {31'd0, tx_valid}, 32'd1);
    check("first_busy", {31'd0, busy}, 32'd1);
  endtask

  // Runs one frame; optional stall at byte stall_at, stray load at load_at,
  // async reset once byte rst_at-1 has been accepted (negative = unused).
  task automatic run_frame(input string name, input logic [399:0] m,
                           input int stall_at, input int load_at, input int rst_at);
    int k, stalls, busy_cycles, done_seen;
    bit ldone;
    k = 0; stalls = 0; busy_cycles = 0; done_seen = 0; ldone = 0;
    do_load(m);
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (k == stall_at && stalls < 5) begin
        tx_ready = 1'b0;
        stalls++;
      end else begin
        tx_ready = 1'b1;
      end
      if (k == load_at && !ldone) begin
        result_in = ~m;
        load = 1'b1;
        ldone = 1;
      end else begin
        load = 1'b0;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        $display("[TB] %s: reset after %0d bytes", name, k);
        return;
      end
      @(negedge clk);
      if (done) begin
        done_seen = 1;
        check("done_valid", {31'd0, tx_valid}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        break;
      end
      if (busy) busy_cycles++;
      if (!tx_ready) begin
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_data}, {24'd0, exp_byte(m, k)});
      end else if (tx_valid) begin
        if (k < 210) begin
          got[k] = tx_data;
          check("byte", {24'd0, tx_data}, {24'd0, exp_byte(m, k)});
        end
        k++;
      end
      @(posedge clk); #1;
    end
    check("done_seen", done_seen, 1);
    check("byte_count", k, 210);
    check("busy_cycles", busy_cycles, 210 + stalls);
    $display("[TB] %s: %0d bytes, %0d busy cycles, done=%0d", name, k, busy_cycles, done_seen);
  endtask

  logic [399:0] m1, m2;

  initial begin
    m1 = '0;
    m1[3:0] = 4'hA;
    m1[7:4] = 4'h3;
    m1[399:396] = 4'h5;
    for (int i = 0; i < 100; i++) m2[i*4 +: 4] = 4'(i % 16);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_valid", {31'd0, tx_valid}, 32'd0);
    check("reset_data", {24'd0, tx_data}, 32'd0);

    run_frame("zeros", '0, -1, -1, -1);
    check("zeros_b0", {24'd0, got[0]}, 32'h30);
    check("zeros_b19", {24'd0, got[19]}, 32'h0D);

    run_frame("sparse", m1, -1, -1, -1);
    check("sparse_b0", {24'd0, got[0]}, 32'h41);
    check("sparse_b1", {24'd0, got[1]}, 32'h20);
    check("sparse_b2", {24'd0, got[2]}, 32'h33);
    check("sparse_b207", {24'd0, got[207]}, 32'h35);
    check("sparse_b208", {24'd0, got[208]}, 32'h0D);
    check("sparse_b209", {24'd0, got[209]}, 32'h0A);

    run_frame("stall", m2, 3, -1, -1);
    run_frame("stray_load", m1, -1, 40, -1);
    run_frame("reset_mid", m2, -1, -1, 51);
    run_frame("after_reset", m2, -1, -1, -1);
    check("after_reset_b0", {24'd0, got[0]}, 32'h30);
    // Called straight from the DONE cycle: load lands in the following cycle.
    run_frame("back_to_back", m2, -1, -1, -1);
    check("hex_F", {24'd0, got[31]}, 32'h46);
    check("hex_A", {24'd0, got[21]}, 32'h41);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
